spi_write_slave: RTL and testbench

//  Synthesizable SPI slave; the receiving end of the 1-byte-address / 1-byte-data SPI write.
//  - Protocol: mode 0 (SCLK idles low, data sampled on SCLK rise), MSB first.
//  - Frame: CS low, 8 address bits, 8 data bits, CS high.
//  - SCLK, CS and SDATA are oversampled by the system clock; completed frames write an

---
 rtl/spi_write_slave.sv | 150 +++++++++++++++
 tb/tb_spi_write_slave.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/spi_write_slave.sv
// SPI mode-0 write slave: oversamples CS/SCLK/SDATA, assembles an 8-bit address plus
// 8-bit data frame and writes it into an internal register bank with a one-cycle strobe.
module spi_write_slave #(
  parameter int          NREG   = 16,
  parameter logic [7:0]  RSTVAL = 8'h00
) (
  input  logic                CLK,
  input  logic                RSTX,
  input  logic                CS,
  input  logic                SCLK,
  input  logic                SDATA,
  output logic                WE,
  output logic [7:0]          WADDR,
  output logic [7:0]          WDATA,
  output logic [NREG*8-1:0]   REGS,
  output logic                BUSY,
  output logic                ABORT
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t      state, state_nxt;
  logic        cs_p0, cs_p1, cs_p2;
  logic        sclk_p0, sclk_p1, sclk_p2;
  logic        sdata_p0, sdata_p1;
  logic        sclk_rise, cs_fall, cs_rise;
  logic        shift_en, frame_done, abort_nxt;
  logic [4:0]  cnt;
  logic [15:0] shreg;
  logic [15:0] frame_w;
  logic        we_r, abort_r;
  logic [7:0]  waddr_r, wdata_r;
  logic [7:0]  regs [NREG];

  // Stage p0/p1: two-flop synchronizers; p2: previous value for edge detection
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      cs_p0    <= 1'b0;
      cs_p1    <= 1'b0;
      cs_p2    <= 1'b0;
      sclk_p0  <= 1'b0;
      sclk_p1  <= 1'b0;
      sclk_p2  <= 1'b0;
      sdata_p0 <= 1'b0;
      sdata_p1 <= 1'b0;
    end else begin
      cs_p0    <= CS;
      cs_p1    <= cs_p0;
      cs_p2    <= cs_p1;
      sclk_p0  <= SCLK;
      sclk_p1  <= sclk_p0;
      sclk_p2  <= sclk_p1;
      sdata_p0 <= SDATA;
      sdata_p1 <= sdata_p0;
    end
  end

  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign cs_fall   = ~cs_p1 & cs_p2;
  assign cs_rise   = cs_p1 & ~cs_p2;
  assign frame_w   = {shreg[14:0], sdata_p1};

  // Frame sequencing
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    abort_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) state_nxt = ADDR;
      end
      ADDR: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          abort_nxt = 1'b1;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
          if (cnt == 5'd7) state_nxt = DATA;
        end
      end
      DATA: begin
        // The 16th bit wins over a simultaneous CS rise: the frame still completes
        if (sclk_rise && cnt == 5'd15) begin
          shift_en   = 1'b1;
          frame_done = 1'b1;
          state_nxt  = cs_rise ? IDLE : DONE;
        end else if (cs_rise) begin
          state_nxt = IDLE;
          abort_nxt = 1'b1;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
        end
      end
      DONE: begin
        if (cs_rise) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p3: shift register, counter and write outputs
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      cnt     <= 5'd0;
      shreg   <= 16'd0;
      we_r    <= 1'b0;
      abort_r <= 1'b0;
      waddr_r <= 8'd0;
      wdata_r <= 8'd0;
    end else begin
      we_r    <= frame_done;
      abort_r <= abort_nxt;
      if (state_nxt == IDLE) cnt <= 5'd0;
      else if (shift_en)     cnt <= cnt + 5'd1;
      if (shift_en) shreg <= frame_w;
      if (frame_done) begin
        waddr_r <= frame_w[15:8];
        wdata_r <= frame_w[7:0];
      end
    end
  end

  // Addresses at or above NREG match no entry and leave the bank untouched
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      for (int i = 0; i < NREG; i++) regs[i] <= RSTVAL;
    end else if (frame_done) begin
      for (int i = 0; i < NREG; i++) begin
        if (frame_w[15:8] == 8'(i)) regs[i] <= frame_w[7:0];
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_regs
    assign REGS[8*g +: 8] = regs[g];
  end

  assign WE    = we_r;
  assign ABORT = abort_r;
  assign WADDR = waddr_r;
  assign WDATA = wdata_r;
  assign BUSY  = (state != IDLE);

endmodule

// File: tb/tb_spi_write_slave.sv
// Bench for spi_write_slave: directed and randomized SPI frames compared against
// a register-bank model built from the frame rules.
module tb_spi_write_slave;
  localparam int         NREG   = 16;
  localparam logic [7:0] RSTVAL = 8'h00;
  localparam int         TCLK   = 20;

  logic                CLK = 1'b0;
  logic                RSTX = 1'b0;
  logic                CS = 1'b1;
  logic                SCLK = 1'b0;
  logic                SDATA = 1'b0;
  logic                WE, BUSY, ABORT;
  logic [7:0]          WADDR, WDATA;
  logic [NREG*8-1:0]   REGS;

  always #(TCLK/2) CLK = ~CLK;

  spi_write_slave #(.NREG(NREG), .RSTVAL(RSTVAL)) dut (
    .CLK(CLK), .RSTX(RSTX), .CS(CS), .SCLK(SCLK), .SDATA(SDATA),
    .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .REGS(REGS),
    .BUSY(BUSY), .ABORT(ABORT)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  int         we_seen = 0;
  int         ab_seen = 0;
  logic [7:0] mon_addr = 8'd0;
  logic [7:0] mon_data = 8'd0;
  logic [7:0] m_regs [NREG];
  logic [7:0] m_waddr, m_wdata;

  // Count strobe cycles; a strobe longer than one CLK shows up as an extra count
  always @(negedge CLK) begin
    if (RSTX) begin
      if (WE) begin
        we_seen  = we_seen + 1;
        mon_addr = WADDR;
        mon_data = WDATA;
      end
      if (ABORT) ab_seen = ab_seen + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = RSTVAL;
    m_waddr = 8'd0;
    m_wdata = 8'd0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, " busy idle"}, 32'(BUSY), 32'd0);
    chk({tag, " waddr"}, 32'(WADDR), 32'(m_waddr));
    chk({tag, " wdata"}, 32'(WDATA), 32'(m_wdata));
    for (int i = 0; i < NREG; i++)
      chk($sformatf("%s reg%0d", tag, i), 32'(REGS[8*i +: 8]), 32'(m_regs[i]));
  endtask

  task automatic spi_bits(input logic [31:0] val, input int nbits, input int half,
                          input bit cs_with_last);
    for (int i = 0; i < nbits; i++) begin
      SDATA = val[nbits-1-i];
      #(half);
      SCLK = 1'b1;
      if (cs_with_last && i == nbits - 1) CS = 1'b1;
      #(half);
      SCLK = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] val, input int nbits, input int half,
                       input bit cs_with_last, input string tag);
    int          we0, ab0;
    logic [15:0] w;
    we0 = we_seen;
    ab0 = ab_seen;
    CS = 1'b0;
    #(half);
    chk({tag, " busy in frame"}, 32'(BUSY), 32'd1);
    spi_bits(val, nbits, half, cs_with_last);
    if (!cs_with_last) begin
      #(half);
      CS = 1'b1;
    end
    #(TCLK*12);
    if (nbits >= 16) begin
      w = 16'(val >> (nbits - 16));
      m_waddr = w[15:8];
      m_wdata = w[7:0];
      if (int'(w[15:8]) < NREG) m_regs[w[15:8]] = w[7:0];
      chk({tag, " strobe addr"}, 32'(mon_addr), 32'(m_waddr));
      chk({tag, " strobe data"}, 32'(mon_data), 32'(m_wdata));
    end
    chk({tag, " we count"}, 32'(we_seen - we0), (nbits >= 16) ? 32'd1 : 32'd0);
    chk({tag, " abort count"}, 32'(ab_seen - ab0), (nbits < 16) ? 32'd1 : 32'd0);
    check_state(tag);
  endtask

  initial begin
    int we0, ab0, nb, half;
    logic [31:0] v;
    model_reset();
    #(TCLK*2 + 5);
    chk("reset we", 32'(WE), 32'd0);
    chk("reset abort", 32'(ABORT), 32'd0);
    check_state("reset");
    RSTX = 1'b1;
    #(TCLK*10);

    frame(32'h03A5, 16, 500, 1'b0, "t1");
    frame(32'h0011, 16, 200, 1'b0, "t2a");
    frame(32'h0FFF, 16, 200, 1'b0, "t2b");
    frame(32'h2AB, 10, 200, 1'b0, "t3 abort");
    frame(32'h013C, 16, 200, 1'b0, "t3 write");
    frame(32'h2077, 16, 200, 1'b0, "t4");
    frame({12'd0, 16'h055A, 4'hF}, 20, 200, 1'b0, "t5");
    frame(32'h0B96, 16, 200, 1'b1, "cs with bit16");

    // Reset in the middle of a frame with CS held low through release
    we0 = we_seen;
    ab0 = ab_seen;
    CS = 1'b0;
    #(200);
    spi_bits(32'hABC, 12, 200, 1'b0);
    RSTX = 1'b0;
    #(TCLK + 7);
    model_reset();
    chk("t6 rst we", 32'(WE), 32'd0);
    check_state("t6 rst");
    RSTX = 1'b1;
    #(TCLK*20);
    chk("t6 cs low after reset busy", 32'(BUSY), 32'd0);
    CS = 1'b1;
    #(TCLK*20);
    chk("t6 we count", 32'(we_seen - we0), 32'd0);
    chk("t6 abort count", 32'(ab_seen - ab0), 32'd0);
    frame(32'h02C3, 16, 200, 1'b0, "t6 write");

    for (int k = 0; k < 20; k++) begin
      half = int'($urandom_range(160, 400));
      case ($urandom_range(0, 5))
        0:       nb = int'($urandom_range(1, 15));
        1:       nb = int'($urandom_range(17, 20));
        default: nb = 16;
      endcase
      v = $urandom;
      v[nb-1 -: 8] = 8'($urandom_range(0, 23));
      frame(v & ((32'd1 << nb) - 32'd1), nb, half, 1'b0, $sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
